// File: rtl/bp_pkg.sv
// Shared definitions for the parametrised branch predictor: legal parameter
// ranges and the saturating-counter arithmetic used by every table entry.
package bp_pkg;

    localparam int ID_W_MIN  = 1;
    localparam int ID_W_MAX  = 16;
    localparam int CTR_W_MIN = 1;
    localparam int CTR_W_MAX = 4;
    localparam int CNT_W_MIN = 1;

    // Largest value a w-bit counter can hold.
    function automatic logic [CTR_W_MAX-1:0] CTR_MAX(input int w);
        return CTR_W_MAX'((1 << w) - 1);
    endfunction

    // Weakly not-taken: one below the taken threshold (0 for a one-bit counter).
    function automatic logic [CTR_W_MAX-1:0] CTR_INIT(input int w);
        return CTR_W_MAX'((1 << (w - 1)) - 1);
    endfunction

    function automatic logic [CTR_W_MAX-1:0] sat_inc(input logic [CTR_W_MAX-1:0] v, input int w);
        return (v >= CTR_MAX(w)) ? v : v + CTR_W_MAX'(1);
    endfunction

    function automatic logic [CTR_W_MAX-1:0] sat_dec(input logic [CTR_W_MAX-1:0] v);
        return (v == '0) ? v : v - CTR_W_MAX'(1);
    endfunction

    function automatic bit params_ok(input int id_w, input int ctr_w, input int hist_w, input int cnt_w);
        return (id_w >= ID_W_MIN) && (id_w <= ID_W_MAX) &&
               (ctr_w >= CTR_W_MIN) && (ctr_w <= CTR_W_MAX) &&
               (hist_w >= 0) && (hist_w <= id_w) &&
               (cnt_w >= CNT_W_MIN);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// One prediction table entry: an up/down counter that sticks at both ends.
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter int               CTR_W = 2,
    parameter logic [CTR_W-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             up_i,
    output logic [CTR_W-1:0] ctr_o
);

    logic [CTR_W-1:0] ctr_q;
    logic [CTR_W-1:0] ctr_d;

    // Next value: step toward the resolved direction, clamped at 0 and max.
    always_comb begin
        ctr_d = ctr_q;
        if (en_i) begin
            if (up_i) ctr_d = CTR_W'(sat_inc(CTR_W_MAX'(ctr_q), CTR_W));
            else      ctr_d = CTR_W'(sat_dec(CTR_W_MAX'(ctr_q)));
        end
    end

    // Counter register; reset restores the weakly-not-taken start value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ctr_q <= INIT;
        else        ctr_q <= ctr_d;
    end

    assign ctr_o = ctr_q;

endmodule

// File: rtl/param_branch_predictor.sv
// Dynamic branch predictor: 2^ID_W saturating counters indexed by branchID,
// optionally XORed with a global outcome history, plus miss/branch statistics.
module param_branch_predictor
    import bp_pkg::*;
#(
    parameter int ID_W   = 3,
    parameter int CTR_W  = 2,
    parameter int HIST_W = 0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [ID_W-1:0]  branchID,
    input  logic             outcome,
    input  logic             clear_stats,
    output logic             predict,
    output logic             miss,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] branch_count
);

    localparam int DEPTH = 1 << ID_W;

    if (!params_ok(ID_W, CTR_W, HIST_W, CNT_W)) begin : g_bad_params
        $error("param_branch_predictor: illegal ID_W/CTR_W/HIST_W/CNT_W combination");
    end

    logic [ID_W-1:0]  idx;
    logic [CTR_W-1:0] ctr_val [DEPTH];
    logic [CTR_W-1:0] ctr_sel;
    logic [CNT_W-1:0] miss_count_q, miss_count_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;

    if (HIST_W == 0) begin : g_bimodal
        assign idx = branchID;
    end else begin : g_gshare
        logic [HIST_W-1:0] ghr_q;
        logic [HIST_W-1:0] ghr_d;

        // Shift the resolved direction into the history on every real branch.
        always_comb begin
            ghr_d = ghr_q;
            if (valid) ghr_d = HIST_W'({ghr_q, outcome});
        end

        // History register.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) ghr_q <= '0;
            else        ghr_q <= ghr_d;
        end

        assign idx = branchID ^ ID_W'(ghr_q);
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_table
        bp_sat_counter #(
            .CTR_W (CTR_W),
            .INIT  (CTR_W'(CTR_INIT(CTR_W)))
        ) u_ctr (
            .clk   (clk),
            .rst_n (reset),
            .en_i  (valid && (idx == ID_W'(i))),
            .up_i  (outcome),
            .ctr_o (ctr_val[i])
        );
    end

    assign ctr_sel = ctr_val[idx];
    assign predict = ctr_sel[CTR_W-1];
    assign miss    = valid & (predict != outcome);

    // Statistics next-state: clear wins over counting; both counters stick at all-ones.
    always_comb begin
        miss_count_d   = miss_count_q;
        branch_count_d = branch_count_q;
        if (clear_stats) begin
            miss_count_d   = '0;
            branch_count_d = '0;
        end else if (valid) begin
            if (branch_count_q != '1)     branch_count_d = branch_count_q + CNT_W'(1);
            if (miss && miss_count_q != '1) miss_count_d = miss_count_q + CNT_W'(1);
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miss_count_q   <= '0;
            branch_count_q <= '0;
        end else begin
            miss_count_q   <= miss_count_d;
            branch_count_q <= branch_count_d;
        end
    end

    assign miss_count   = miss_count_q;
    assign branch_count = branch_count_q;

endmodule

// File: tb/tb_param_branch_predictor.sv
// Bench for param_branch_predictor: three configurations share one stimulus
// stream and are checked against an array-based model plus fixed vectors.
module tb_param_branch_predictor;

    logic       clk;
    logic       rst_n;
    logic       t_v;
    logic [2:0] t_id;
    logic       t_o;
    logic       t_clr;

    logic        p0, p1, p2, m0, m1, m2;
    logic [15:0] mc0, bc0, mc1, bc1;
    logic [3:0]  mc2, bc2;

    param_branch_predictor #(.ID_W(3), .CTR_W(2), .HIST_W(0), .CNT_W(16)) u0 (
        .clk(clk), .reset(rst_n), .valid(t_v), .branchID(t_id), .outcome(t_o),
        .clear_stats(t_clr), .predict(p0), .miss(m0), .miss_count(mc0), .branch_count(bc0));
    param_branch_predictor #(.ID_W(3), .CTR_W(1), .HIST_W(0), .CNT_W(16)) u1 (
        .clk(clk), .reset(rst_n), .valid(t_v), .branchID(t_id), .outcome(t_o),
        .clear_stats(t_clr), .predict(p1), .miss(m1), .miss_count(mc1), .branch_count(bc1));
    param_branch_predictor #(.ID_W(3), .CTR_W(2), .HIST_W(2), .CNT_W(4)) u2 (
        .clk(clk), .reset(rst_n), .valid(t_v), .branchID(t_id), .outcome(t_o),
        .clear_stats(t_clr), .predict(p2), .miss(m2), .miss_count(mc2), .branch_count(bc2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int cfg_ctr  [3] = '{2, 1, 2};
    int cfg_hist [3] = '{0, 0, 2};
    int cfg_cnt  [3] = '{16, 16, 4};
    int m_tbl [3][8];
    int m_ghr [3];
    int m_mc  [3];
    int m_bc  [3];

    typedef struct {
        bit v; int id; bit o; bit clr;
        bit ep; bit em; int emc; int ebc;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int a_pred(int k);
        case (k) 0: return int'(p0); 1: return int'(p1); default: return int'(p2); endcase
    endfunction
    function automatic int a_miss(int k);
        case (k) 0: return int'(m0); 1: return int'(m1); default: return int'(m2); endcase
    endfunction
    function automatic int a_mc(int k);
        case (k) 0: return int'(mc0); 1: return int'(mc1); default: return int'(mc2); endcase
    endfunction
    function automatic int a_bc(int k);
        case (k) 0: return int'(bc0); 1: return int'(bc1); default: return int'(bc2); endcase
    endfunction

    function automatic int m_idx(int k, int id);
        return id ^ m_ghr[k];
    endfunction
    function automatic bit m_pred(int k, int id);
        return m_tbl[k][m_idx(k, id)] >= (1 << (cfg_ctr[k] - 1));
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 3; k++) begin
            for (int e = 0; e < 8; e++) m_tbl[k][e] = (1 << (cfg_ctr[k] - 1)) - 1;
            m_ghr[k] = 0; m_mc[k] = 0; m_bc[k] = 0;
        end
    endtask

    task automatic m_update();
        for (int k = 0; k < 3; k++) begin
            int i, tmax, cmax; bit p, ms;
            i    = m_idx(k, int'(t_id));
            p    = m_pred(k, int'(t_id));
            ms   = t_v && (p != t_o);
            tmax = (1 << cfg_ctr[k]) - 1;
            cmax = (1 << cfg_cnt[k]) - 1;
            if (t_clr) begin
                m_mc[k] = 0; m_bc[k] = 0;
            end else if (t_v) begin
                if (m_bc[k] < cmax) m_bc[k]++;
                if (ms && m_mc[k] < cmax) m_mc[k]++;
            end
            if (t_v) begin
                if (t_o && m_tbl[k][i] < tmax) m_tbl[k][i]++;
                if (!t_o && m_tbl[k][i] > 0)   m_tbl[k][i]--;
                if (cfg_hist[k] > 0) m_ghr[k] = ((m_ghr[k] << 1) | int'(t_o)) % (1 << cfg_hist[k]);
            end
        end
    endtask

    task automatic model_cmp();
        for (int k = 0; k < 3; k++) begin
            bit ep;
            ep = m_pred(k, int'(t_id));
            chk($sformatf("model_pred%0d", k), a_pred(k), int'(ep));
            chk($sformatf("model_miss%0d", k), a_miss(k), int'(t_v && (ep != t_o)));
            chk($sformatf("model_mc%0d", k), a_mc(k), m_mc[k]);
            chk($sformatf("model_bc%0d", k), a_bc(k), m_bc[k]);
        end
    endtask

    // Present inputs (called just after a posedge) and compare at the negedge.
    task automatic apply(input bit v, input int id, input bit o, input bit clr);
        t_v = v; t_id = 3'(id); t_o = o; t_clr = clr;
        @(negedge clk);
        model_cmp();
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst_n) m_update();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        #2;
        rst_n = 1'b1;
    endtask

    function automatic void add(bit v, int id, bit o, bit clr, bit ep, bit em, int emc, int ebc);
        vec_t r;
        r.v = v; r.id = id; r.o = o; r.clr = clr; r.ep = ep; r.em = em; r.emc = emc; r.ebc = ebc;
        vt.push_back(r);
    endfunction

    initial begin
        int id;
        bit o;
        // Default configuration: train ID0, saturate ID3, idle, then clear with a miss.
        add(1, 0, 1, 0, 0, 1, 0, 0);
        add(1, 0, 1, 0, 1, 0, 1, 1);
        add(0, 0, 1, 0, 1, 0, 1, 2);
        add(1, 3, 1, 0, 0, 1, 1, 2);
        add(1, 3, 1, 0, 1, 0, 2, 3);
        add(1, 3, 1, 0, 1, 0, 2, 4);
        add(1, 3, 1, 0, 1, 0, 2, 5);
        add(1, 3, 1, 0, 1, 0, 2, 6);
        add(1, 3, 1, 0, 1, 0, 2, 7);
        add(1, 3, 0, 0, 1, 1, 2, 8);
        add(1, 3, 1, 0, 1, 0, 3, 9);
        for (int i = 0; i < 5; i++) add(0, 3, 0, 0, 1, 0, 3, 10);
        add(1, 5, 1, 1, 0, 1, 3, 10);
        add(0, 5, 0, 0, 1, 0, 0, 0);

        rst_n = 1'b0; t_v = 1'b1; t_id = 3'd0; t_o = 1'b1; t_clr = 1'b0;
        m_reset();
        @(negedge clk);
        chk("reset_pred0", int'(p0), 0);
        chk("reset_pred1", int'(p1), 0);
        chk("reset_pred2", int'(p2), 0);
        chk("reset_miss0", int'(m0), 1);
        chk("reset_mc0", int'(mc0), 0);
        chk("reset_bc2", int'(bc2), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vt[i]) begin
            apply(vt[i].v, vt[i].id, vt[i].o, vt[i].clr);
            chk($sformatf("vec%0d_pred", i), int'(p0), int'(vt[i].ep));
            chk($sformatf("vec%0d_miss", i), int'(m0), int'(vt[i].em));
            chk($sformatf("vec%0d_mc", i), int'(mc0), vt[i].emc);
            chk($sformatf("vec%0d_bc", i), int'(bc0), vt[i].ebc);
            adv();
        end

        // One-bit counters: alternating T,N,T,N on ID2 misses every time.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(1, 2, (i % 2) == 0, 0);
            chk($sformatf("ctr1_miss%0d", i), int'(m1), 1);
            adv();
        end
        apply(0, 2, 0, 0);
        chk("ctr1_miss_count", int'(mc1), 4);
        adv();

        // Two-bit history: after T,T the ghr is 2'b11.
        do_reset();
        apply(1, 0, 1, 0); adv();
        apply(1, 0, 1, 0); adv();
        apply(0, 1, 0, 0);
        chk("hist_id1_idx2_pred", int'(p2), 0);
        adv();
        apply(0, 3, 0, 0);
        chk("hist_id3_idx0_pred", int'(p2), 1);
        adv();

        // Four-bit statistics: 20 forced misses saturate at 15.
        for (int i = 0; i < 20; i++) begin
            id = int'($urandom_range(0, 7));
            o  = !m_pred(2, id);
            apply(1, id, o, 0);
            chk($sformatf("cnt4_forced_miss%0d", i), int'(m2), 1);
            adv();
        end
        apply(0, 0, 0, 0);
        chk("cnt4_miss_sat", int'(mc2), 15);
        chk("cnt4_branch_sat", int'(bc2), 15);
        adv();

        // Asynchronous reset between edges wipes training immediately.
        do_reset();
        apply(1, 0, 1, 0); adv();
        apply(1, 0, 1, 0); adv();
        apply(1, 0, 1, 0);
        chk("trained_pred", int'(p0), 1);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("async_rst_pred", int'(p0), 0);
        chk("async_rst_miss", int'(m0), 1);
        chk("async_rst_mc", int'(mc0), 0);
        chk("async_rst_bc", int'(bc0), 0);
        model_cmp();
        adv();
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            apply(($urandom % 4) != 0, int'($urandom_range(0, 7)), 1'($urandom), ($urandom % 32) == 0);
            adv();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
